// File: rtl/iter_sequencer.sv
// iter_sequencer: iteration control FSM for multi-cycle ALU operations.
// It clears the external up/down step counter, then issues exactly ITERATIONS
// count pulses in the latched direction, with one datapath step strobe per
// pulse. The final step is found by comparing the fed-back counter value
// against the last expected value. Completion is reported through done/ack.
module iter_sequencer #(
  parameter int WIDTH      = 3,
  parameter int ITERATIONS = 8
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active-low
  input  logic             start,
  input  logic             op,         // 0: up-sequence, 1: down-sequence
  input  logic             hold,
  input  logic             abort,
  input  logic             ack,
  input  logic [WIDTH-1:0] cnt,
  output logic             cnt_clr,
  output logic             count_up,
  output logic             count_down,
  output logic             step,
  output logic             ready,
  output logic             busy,
  output logic             done
);

  localparam int CNT_MOD = 2 ** WIDTH;

  // A sequence longer than the counter range would never see a unique final value.
  if (ITERATIONS < 1 || ITERATIONS > CNT_MOD) begin : g_bad_iterations
    $error("iter_sequencer: ITERATIONS must be in 1..2**WIDTH");
  end

  // Counter value seen on the final step of each direction. The down-sequence
  // starts at 0 and wraps to the maximum, so step k sees (-k) mod 2**WIDTH.
  localparam logic [WIDTH-1:0] LAST_UP = WIDTH'(ITERATIONS - 1);
  localparam logic [WIDTH-1:0] LAST_DN = WIDTH'((CNT_MOD - ITERATIONS + 1) % CNT_MOD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;
  logic   op_q, op_d;
  logic   last_step;

  assign last_step = (cnt == (op_q ? LAST_DN : LAST_UP));

  // State and direction registers; reset returns to IDLE immediately.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state and output decode; outputs are combinational so the counter
  // acts on them in the same cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    op_d       = op_q;
    cnt_clr    = 1'b0;
    count_up   = 1'b0;
    count_down = 1'b0;
    step       = 1'b0;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          op_d    = op;
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        cnt_clr = 1'b1;
        busy    = 1'b1;
        state_d = abort ? S_IDLE : S_RUN;
      end

      S_RUN: begin
        busy = 1'b1;
        // Abort wins over both hold and the final step: no pulse is issued.
        if (abort) begin
          state_d = S_IDLE;
        end else if (!hold) begin
          step       = 1'b1;
          count_up   = ~op_q;
          count_down = op_q;
          if (last_step) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        done = 1'b1;
        if (ack) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_iter_sequencer.sv
// Testbench for iter_sequencer. Three instances (ITERATIONS = 8, 5, 1) each
// drive a small up/down counter model. The stimulus process drives one
// instance per cycle and pushes the hand-derived expected outputs for that
// cycle into a scoreboard queue; a monitor pops and compares on the falling
// edge.
module tb_iter_sequencer;

  // Expected-output field layout: {cnt_clr, count_up, count_down, step, ready, busy, done}
  localparam logic [6:0] O_IDLE = 7'b0000100;
  localparam logic [6:0] O_CLR  = 7'b1000010;
  localparam logic [6:0] O_UP   = 7'b0101010;
  localparam logic [6:0] O_DN   = 7'b0011010;
  localparam logic [6:0] O_BUSY = 7'b0000010;
  localparam logic [6:0] O_DONE = 7'b0000001;

  typedef struct {
    int          dut;
    logic [9:0]  vec;   // {outputs[6:0], cnt[2:0]}
    string       name;
  } exp_t;

  exp_t sb[$];

  logic clk;
  logic reset;
  logic [2:0] start_v, op_v, hold_v, abort_v, ack_v;
  logic [2:0][9:0] obs;

  int n_vec = 0;
  int n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int IT = (gi == 0) ? 8 : ((gi == 1) ? 5 : 1);
    logic [2:0] cnt_m = 3'd5;
    logic clr, up, dn, stp, rdy, bsy, dne;

    iter_sequencer #(.WIDTH(3), .ITERATIONS(IT)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start_v[gi]),
      .op         (op_v[gi]),
      .hold       (hold_v[gi]),
      .abort      (abort_v[gi]),
      .ack        (ack_v[gi]),
      .cnt        (cnt_m),
      .cnt_clr    (clr),
      .count_up   (up),
      .count_down (dn),
      .step       (stp),
      .ready      (rdy),
      .busy       (bsy),
      .done       (dne)
    );

    // Counter model: not reset, so a reset mid-operation leaves its value.
    always @(posedge clk) begin
      if (clr)     cnt_m <= 3'd0;
      else if (up) cnt_m <= cnt_m + 3'd1;
      else if (dn) cnt_m <= cnt_m - 3'd1;
    end

    assign obs[gi] = {clr, up, dn, stp, rdy, bsy, dne, cnt_m};
  end

  // Monitor: compare one scoreboard entry per cycle, mid-cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if (obs[e.dut] !== e.vec) begin
        n_bad++;
        $display("FAIL %s (dut%0d): got %b cnt=%0d, expected %b cnt=%0d",
                 e.name, e.dut, obs[e.dut][9:3], obs[e.dut][2:0], e.vec[9:3], e.vec[2:0]);
      end
    end
  end

  // Drive one cycle on instance d and record what it must show in that cycle.
  task automatic apply(input int d, input logic s, input logic o, input logic h,
                       input logic a, input logic k, input logic [6:0] outs,
                       input logic [2:0] c, input string nm);
    start_v = '0; op_v = '0; hold_v = '0; abort_v = '0; ack_v = '0;
    start_v[d] = s; op_v[d] = o; hold_v[d] = h; abort_v[d] = a; ack_v[d] = k;
    sb.push_back('{d, {outs, c}, nm});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d, input logic [2:0] c, input string nm);
    apply(d, 0, 0, 0, 0, 0, O_IDLE, c, nm);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reset   = 1'b0;
    start_v = '0; op_v = '0; hold_v = '0; abort_v = '0; ack_v = '0;
    @(posedge clk);
    #1;
    idle(0, 3'd5, "reset_state");
    reset = 1'b1;

    // Up-sequence, ITERATIONS=8, no hold: done in cycle 10 after start.
    idle(0, 3'd5, "idle_after_reset");
    apply(0, 1, 0, 0, 0, 0, O_IDLE, 3'd5, "up_start");
    apply(0, 0, 0, 0, 0, 0, O_CLR,  3'd5, "up_clear");
    for (int k = 0; k < 8; k++) apply(0, 0, 0, 0, 0, 0, O_UP, 3'(k), "up_step");
    apply(0, 0, 0, 0, 0, 1, O_DONE, 3'd0, "up_done_cycle10");
    idle(0, 3'd0, "up_idle_after_ack");

    // Up-sequence with 3 hold cycles, then a stretched DONE handshake.
    apply(0, 1, 0, 0, 0, 0, O_IDLE, 3'd0, "hold_start");
    apply(0, 0, 0, 0, 0, 0, O_CLR,  3'd0, "hold_clear");
    for (int k = 0; k < 4; k++) apply(0, 0, 0, 0, 0, 0, O_UP, 3'(k), "hold_step_a");
    for (int k = 0; k < 3; k++) apply(0, 0, 0, 1, 0, 0, O_BUSY, 3'd4, "hold_frozen");
    for (int k = 4; k < 8; k++) apply(0, 0, 0, 0, 0, 0, O_UP, 3'(k), "hold_step_b");
    apply(0, 1, 0, 0, 0, 0, O_DONE, 3'd0, "hs_done13_start_ignored");
    apply(0, 0, 0, 1, 0, 0, O_DONE, 3'd0, "hs_done_hold_ignored");
    apply(0, 0, 0, 0, 1, 0, O_DONE, 3'd0, "hs_done_abort_ignored");
    apply(0, 0, 0, 0, 0, 0, O_DONE, 3'd0, "hs_done_wait4");
    apply(0, 0, 0, 0, 0, 0, O_DONE, 3'd0, "hs_done_wait5");
    apply(0, 0, 0, 0, 0, 1, O_DONE, 3'd0, "hs_done_ack");
    idle(0, 3'd0, "hs_idle");
    idle(0, 3'd0, "hs_start_not_queued");

    // Abort in RUN at cnt=4: no step that cycle, IDLE next, no further pulses.
    apply(0, 1, 0, 0, 0, 0, O_IDLE, 3'd0, "abrun_start");
    apply(0, 0, 0, 0, 0, 0, O_CLR,  3'd0, "abrun_clear");
    for (int k = 0; k < 4; k++) apply(0, 0, 0, 0, 0, 0, O_UP, 3'(k), "abrun_step");
    apply(0, 0, 0, 0, 1, 0, O_BUSY, 3'd4, "abrun_no_step");
    idle(0, 3'd4, "abrun_idle");
    idle(0, 3'd4, "abrun_idle_quiet");

    // Abort in CLEAR: the clear still happens, but no step follows.
    apply(0, 1, 0, 0, 0, 0, O_IDLE, 3'd4, "abclr_start");
    apply(0, 0, 0, 0, 1, 0, O_CLR,  3'd4, "abclr_clear");
    idle(0, 3'd0, "abclr_idle");
    idle(0, 3'd0, "abclr_idle_quiet");

    // Down-sequence, ITERATIONS=5: cnt 0,7,6,5,4 then done at 3.
    idle(1, 3'd5, "dn_idle");
    apply(1, 1, 1, 0, 0, 0, O_IDLE, 3'd5, "dn_start");
    apply(1, 0, 0, 0, 0, 0, O_CLR,  3'd5, "dn_clear");
    for (int k = 0; k < 5; k++) apply(1, 0, 0, 0, 0, 0, O_DN, 3'(0 - k), "dn_step");
    apply(1, 0, 0, 0, 0, 1, O_DONE, 3'd3, "dn_done");
    idle(1, 3'd3, "dn_idle_after_ack");

    // ITERATIONS=1, both directions: a single step, then DONE.
    apply(2, 1, 0, 0, 0, 0, O_IDLE, 3'd5, "one_up_start");
    apply(2, 0, 0, 0, 0, 0, O_CLR,  3'd5, "one_up_clear");
    apply(2, 0, 0, 0, 0, 0, O_UP,   3'd0, "one_up_step");
    apply(2, 0, 0, 0, 0, 1, O_DONE, 3'd1, "one_up_done");
    idle(2, 3'd1, "one_up_idle");
    apply(2, 1, 1, 0, 0, 0, O_IDLE, 3'd1, "one_dn_start");
    apply(2, 0, 0, 0, 0, 0, O_CLR,  3'd1, "one_dn_clear");
    apply(2, 0, 0, 0, 0, 0, O_DN,   3'd0, "one_dn_step");
    apply(2, 0, 0, 0, 0, 1, O_DONE, 3'd7, "one_dn_done");
    idle(2, 3'd7, "one_dn_idle");

    // Reset dropped mid-RUN: outputs fall to reset values before any edge.
    apply(0, 1, 0, 0, 0, 0, O_IDLE, 3'd0, "rst_start");
    apply(0, 0, 0, 0, 0, 0, O_CLR,  3'd0, "rst_clear");
    apply(0, 0, 0, 0, 0, 0, O_UP,   3'd0, "rst_step0");
    apply(0, 0, 0, 0, 0, 0, O_UP,   3'd1, "rst_step1");
    sb.push_back('{0, {O_IDLE, 3'd2}, "rst_async"});
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    sb.push_back('{0, {O_IDLE, 3'd2}, "rst_held"});
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(0, 3'd2, "rst_ready_after_release");
    idle(0, 3'd2, "rst_stays_idle");

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/iter_sequencer.md
# iter_sequencer

Iteration control FSM that sits directly upstream of the datapath's up/down step counter. It clears the counter, issues exactly `ITERATIONS` count pulses in the selected direction, and emits a per-step strobe for the shift/add datapath. It watches the counter's value to detect the final step, then reports completion through a done/ack handshake. It is the sequencing core for multi-cycle ALU operations.

## Interface
- `WIDTH`, 3: width of the counter value `cnt`.
- `ITERATIONS`, 8: steps per operation. Legal range is 1..2**WIDTH; elaboration fails outside it.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; forces IDLE immediately.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `op`  in  1  direction: 0 selects up-sequence, 1 selects down-sequence; latched with `start`.
- `hold`  in  1  stall request; freezes stepping while in RUN.
- `abort`  in  1  cancel the operation from CLEAR or RUN.
- `ack`  in  1  consumer acknowledge of `done`; sampled only in DONE.
- `cnt`  in  WIDTH  current counter value, fed back from the counter.
- `cnt_clr`  out  1  counter clear pulse, active-high.
- `count_up`  out  1  counter increment enable.
- `count_down`  out  1  counter decrement enable.
- `step`  out  1  datapath step strobe; one pulse per iteration.
- `ready`  out  1  high in IDLE.
- `busy`  out  1  high in CLEAR or RUN.
- `done`  out  1  high in DONE; held until `ack`.

## Operation
- State register: IDLE, CLEAR, RUN, DONE. A 1-bit `op_q` holds the latched direction. No other storage.
- IDLE:
  - `ready`=1.
  - `start`=1 latches `op` into `op_q` and moves to CLEAR.
- CLEAR:
  - `cnt_clr`=1 for exactly one cycle; the counter reads 0 in the following cycle.
  - `abort`=1 moves to IDLE; otherwise the next state is RUN.
- RUN, with `hold`=0:
  - `step`=1.
  - `count_up`=~`op_q` and `count_down`=`op_q`.
  - The counter advances on the same edge that ends the cycle.
- RUN, with `hold`=1: `step`, `count_up` and `count_down` are all 0, and the state is unchanged.
- Final-step value `LAST`:
  - Up-sequence: `ITERATIONS`-1.
  - Down-sequence: (2**WIDTH − `ITERATIONS` + 1) mod 2**WIDTH.
  - Step k (from 0) sees `cnt` = k for up, and (−k) mod 2**WIDTH for down, which wraps 0→max.
- RUN exit:
  - `hold`=0 and `cnt`==`LAST` → DONE, after this final step is issued.
  - `abort`=1 → IDLE with no step; `abort` has priority over `hold` and over the final step.
- DONE:
  - `done`=1.
  - `ack`=1 → IDLE.
  - `start`, `hold` and `abort` are ignored.
- `count_up` and `count_down` are never both 1.
- All outputs are decoded combinationally from the state register, `op_q`, `hold`, `abort` and `cnt`. They are not registered, so the counter sees them in the same cycle.

## Timing
- Reset values: state = IDLE, `op_q`=0, `ready`=1, and all other outputs = 0.
- Reset asserted mid-operation: return to IDLE at once. No `done` is produced and the counter is not cleared.
- Latency with no hold:
  - Edge 0 samples `start`.
  - CLEAR occupies cycle 1.
  - RUN occupies cycles 2..`ITERATIONS`+1.
  - `done` rises in cycle `ITERATIONS`+2.
- Each hold cycle in RUN adds exactly one cycle to this latency.
- `ack` in the first DONE cycle gives IDLE, with `ready`=1, in the next cycle.
- The earliest back-to-back `start` is in the cycle after `ack`.
- `start` asserted while not in IDLE is dropped. It is not queued.
- Exactly `ITERATIONS` `step` pulses occur per completed operation, and none occur after abort.

## Test plan
- Up-sequence with WIDTH=3, ITERATIONS=8, op=0 and no hold:
  - `cnt_clr` pulses once, followed by 8 `step`/`count_up` cycles.
  - `cnt` reads 0..7, then wraps to 0.
  - `done` is high in cycle 10 after `start`; `ack` returns to IDLE.
- Down-sequence with ITERATIONS=5, op=1:
  - `cnt` reads 0,7,6,5,4 during the 5 steps with `count_down`=1.
  - The sequence ends at `cnt`=3 with `done` high; `count_up` stays 0 throughout.
- Up-sequence with ITERATIONS=8 and `hold` asserted for 3 cycles mid-RUN:
  - No step or count pulse occurs during the hold.
  - `done` is delayed to cycle 13.
  - Total `step` pulses equal 8.
- Abort:
  - `abort` in RUN at `cnt`=4 gives IDLE next cycle, no `done`, and no further pulses.
  - `abort` in CLEAR gives IDLE with no step.
- Handshake:
  - Hold `ack`=0 for 5 cycles in DONE; `done` stays 1, and a `start` pulse during DONE is ignored.
  - Then `ack`=1 gives IDLE.
- Reset and limits:
  - Drop `reset` low mid-RUN: all outputs drop to reset values asynchronously, and `ready`=1 after release.
  - ITERATIONS=1 gives exactly one step, then DONE.
